// File: rtl/lcd1602_bus_wr_if.sv
// Request/completion handshake from the LCD sequencers plus the HD44780 pin bundle.
// wr_en is a one-cycle request taken only while busy=0; wr_done pulses once per accepted byte.
interface lcd1602_bus_wr_if;
    logic       wr_en;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    modport master (
        output wr_en, wr_rs, wr_data,
        input  wr_done, busy, lcd_rs, lcd_rw, lcd_en, lcd_data
    );

    modport slave (
        input  wr_en, wr_rs, wr_data,
        output wr_done, busy, lcd_rs, lcd_rw, lcd_en, lcd_data
    );
endinterface

// File: rtl/lcd1602_bus_wr.sv
// Write-only HD44780 bus driver: latches one byte, strobes E with setup/hold margins,
// then waits out the controller execution time before pulsing wr_done.
module lcd1602_bus_wr #(
    parameter int T_SETUP     = 3,
    parameter int T_EN_HIGH   = 15,
    parameter int T_HOLD      = 3,
    parameter int T_EXEC      = 2500,
    parameter int T_EXEC_LONG = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    lcd1602_bus_wr_if.slave       bus,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EN_HI = 3'd2,
        HOLD  = 3'd3,
        EXEC  = 3'd4
    } state_t;

    localparam logic [16:0] SETUP_LAST = 17'(T_SETUP - 1);
    localparam logic [16:0] EN_LAST    = 17'(T_EN_HIGH - 1);
    localparam logic [16:0] HOLD_LAST  = 17'(T_HOLD - 1);
    localparam logic [16:0] EXEC_LAST  = 17'(T_EXEC - 1);
    localparam logic [16:0] LONG_LAST  = 17'(T_EXEC_LONG - 1);

    state_t      state;
    logic [16:0] cnt;
    logic        wr_done_r;
    logic        busy_r;
    logic        lcd_rs_r;
    logic        lcd_en_r;
    logic [7:0]  lcd_data_r;
    logic        is_long;
    logic [16:0] exec_last;

    // Clear Display (01) and Return Home (02/03) take ~1.52 ms on the controller.
    assign is_long   = !lcd_rs_r && (lcd_data_r == 8'h01 || lcd_data_r == 8'h02 ||
                                     lcd_data_r == 8'h03);
    assign exec_last = is_long ? LONG_LAST : EXEC_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_done_r  <= 1'b0;
            busy_r     <= 1'b0;
            lcd_rs_r   <= 1'b0;
            lcd_en_r   <= 1'b0;
            lcd_data_r <= 8'h00;
        end else begin
            wr_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.wr_en) begin
                        lcd_rs_r   <= bus.wr_rs;
                        lcd_data_r <= bus.wr_data;
                        busy_r     <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt      <= '0;
                        lcd_en_r <= 1'b1;
                        state    <= EN_HI;
                    end else begin
                        cnt <= cnt + 17'd1;
                    end
                end
                EN_HI: begin
                    if (cnt == EN_LAST) begin
                        cnt      <= '0;
                        lcd_en_r <= 1'b0;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt + 17'd1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= EXEC;
                    end else begin
                        cnt <= cnt + 17'd1;
                    end
                end
                EXEC: begin
                    // RS/DB stay on the pins after completion; only a new request changes them.
                    if (cnt == exec_last) begin
                        cnt       <= '0;
                        busy_r    <= 1'b0;
                        wr_done_r <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 17'd1;
                    end
                end
                default: begin
                    cnt      <= '0;
                    lcd_en_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_done  = wr_done_r;
    assign bus.busy     = busy_r;
    assign bus.lcd_rs   = lcd_rs_r;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_en   = lcd_en_r;
    assign bus.lcd_data = lcd_data_r;
    assign dbg_state    = state;
endmodule

// File: tb/tb_lcd1602_bus_wr.sv
// Directed bench for lcd1602_bus_wr with shortened execution waits so long instructions stay cheap.
module tb_lcd1602_bus_wr;
  localparam int T_SETUP     = 3;
  localparam int T_EN_HIGH   = 15;
  localparam int T_HOLD      = 3;
  localparam int T_EXEC      = 100;
  localparam int T_EXEC_LONG = 400;
  // Acceptance edge to wr_done edge: 3 + 15 + 3 + exec wait.
  localparam int LAT_N       = 121;
  localparam int LAT_L       = 421;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] dbg_state;
  int cyc = 0;
  int done_cnt = 0;
  logic rw_bad = 1'b0;
  int n_chk = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  lcd1602_bus_wr_if bus();

  lcd1602_bus_wr #(
    .T_SETUP(T_SETUP), .T_EN_HIGH(T_EN_HIGH), .T_HOLD(T_HOLD),
    .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_done === 1'b1) done_cnt++;
    if (bus.lcd_rw !== 1'b0) rw_bad = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; presents the request there so it is taken on the next posedge.
  // Returns at the negedge where wr_done is seen (or after a cycle budget).
  task automatic do_write(input logic rs, input logic [7:0] d, input int g1, input int g2,
                          output int en_rise, output int en_len, output int lat,
                          output logic stable, output logic busy0, output logic done_busy);
    int acc;
    int off;
    bus.wr_en   = 1'b1;
    bus.wr_rs   = rs;
    bus.wr_data = d;
    acc = cyc + 1;
    en_rise = -1;
    en_len = 0;
    lat = -1;
    stable = 1'b1;
    busy0 = 1'b0;
    done_busy = 1'b1;
    for (int i = 0; i < T_EXEC_LONG + 200; i++) begin
      @(negedge clk);
      off = cyc - acc;
      if (off == g1 || off == g2) begin
        bus.wr_en   = 1'b1;
        bus.wr_rs   = 1'b1;
        bus.wr_data = 8'hFF;
      end else begin
        bus.wr_en   = 1'b0;
        bus.wr_rs   = ~rs;
        bus.wr_data = ~d;
      end
      if (off == 0) busy0 = bus.busy;
      if (bus.lcd_data !== d || bus.lcd_rs !== rs) stable = 1'b0;
      if (bus.lcd_en === 1'b1) begin
        if (en_rise < 0) en_rise = off;
        en_len++;
      end
      if (bus.wr_done === 1'b1) begin
        lat = off;
        done_busy = bus.busy;
        break;
      end
    end
  endtask

  task automatic run_checked(input string tag, input logic rs, input logic [7:0] d,
                             input int g1, input int g2, input int exp_lat);
    int en_rise, en_len, lat;
    logic stable, busy0, done_busy;
    do_write(rs, d, g1, g2, en_rise, en_len, lat, stable, busy0, done_busy);
    check({tag, " busy_after_accept"}, int'(busy0), 1);
    check({tag, " rs_data_held"}, int'(stable), 1);
    check({tag, " en_rise"}, en_rise, T_SETUP);
    check({tag, " en_len"}, en_len, T_EN_HIGH);
    check({tag, " done_latency"}, lat, exp_lat);
    check({tag, " busy_at_done"}, int'(done_busy), 0);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         lat;
  } vec_t;

  vec_t vt[8];
  logic [7:0] seq[8];
  int d0;

  initial begin
    vt[0] = '{1'b0, 8'h38, LAT_N};
    vt[1] = '{1'b0, 8'h01, LAT_L};
    vt[2] = '{1'b0, 8'h02, LAT_L};
    vt[3] = '{1'b0, 8'h03, LAT_L};
    vt[4] = '{1'b0, 8'h04, LAT_N};
    vt[5] = '{1'b1, 8'h41, LAT_N};
    vt[6] = '{1'b1, 8'h01, LAT_N};
    vt[7] = '{1'b0, 8'h00, LAT_N};
    seq[0] = 8'h38; seq[1] = 8'h38; seq[2] = 8'h38; seq[3] = 8'h38;
    seq[4] = 8'h08; seq[5] = 8'h01; seq[6] = 8'h06; seq[7] = 8'h0C;

    // Clock/reset
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_rs = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset busy", int'(bus.busy), 0);
    check("reset wr_done", int'(bus.wr_done), 0);
    check("reset lcd_en", int'(bus.lcd_en), 0);
    check("reset lcd_rs", int'(bus.lcd_rs), 0);
    check("reset lcd_data", int'(bus.lcd_data), 8'h00);
    check("reset state", int'(dbg_state), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, chained: each request rides the wr_done cycle of the previous one
    for (int i = 0; i < 8; i++)
      run_checked($sformatf("vec%0d", i), vt[i].rs, vt[i].d, -1, -1, vt[i].lat);

    // Requests while busy (one during E high, one during exec wait) must be ignored
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    run_checked("ignore", 1'b0, 8'h38, 10, 100, LAT_N);
    repeat (5) @(negedge clk);
    check("ignore done_count", done_cnt - d0, 1);
    check("ignore idle_after", int'(bus.busy), 0);

    // Back-to-back init-style sequence
    for (int i = 0; i < 8; i++)
      run_checked($sformatf("seq%0d", i), 1'b0, seq[i], -1, -1,
                  (seq[i] == 8'h01) ? LAT_L : LAT_N);
    repeat (3) @(negedge clk);

    // Reset during E high aborts the byte with no completion
    bus.wr_en = 1'b1;
    bus.wr_rs = 1'b1;
    bus.wr_data = 8'h5A;
    @(negedge clk);
    bus.wr_en = 1'b0;
    for (int i = 0; i < 20 && bus.lcd_en !== 1'b1; i++) @(negedge clk);
    check("abort reached_en_hi", int'(bus.lcd_en), 1);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("abort lcd_en", int'(bus.lcd_en), 0);
    check("abort lcd_data", int'(bus.lcd_data), 8'h00);
    check("abort lcd_rs", int'(bus.lcd_rs), 0);
    check("abort busy", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (T_EXEC_LONG + 50) @(negedge clk);
    check("abort no_done", done_cnt - d0, 0);
    check("abort still_idle", int'(dbg_state), 0);

    run_checked("post_reset", 1'b1, 8'h41, -1, -1, LAT_N);
    check("lcd_rw_always_0", int'(rw_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
